// File: rtl/poly_pkg.sv
// Shared constants for the polynomial-multiplication datapath:
// default operand width, the BN254 scalar-field prime and the op encoding.
package poly_pkg;

   localparam int DATA_W_DEF = 256;

   localparam logic [DATA_W_DEF-1:0] FIELD_P =
      256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: loads d when en is high, clears to zero on
// asynchronous active-low reset. One instance holds a whole stage bundle.
module pipe_stage_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Hold the bundle unless the stage is allowed to advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor, (a+b) mod P or (a-b) mod P,
// with valid/ready handshake and full backpressure at one result per cycle.
// Stage 1 forms the raw sum/difference, stage 2 applies a single correction.
// Optional build macro MOD_ADDSUB_RANGE_CHK_EN adds an out_err flag marking
// results whose operands were not reduced (>= P).
module mod_addsub_pipe
   import poly_pkg::*;
#(
   parameter int                DATA_W  = DATA_W_DEF,
   parameter logic [DATA_W-1:0] MODULUS = FIELD_P,
   parameter int                TAG_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_res,
   output logic [TAG_W-1:0]  out_tag
`ifdef MOD_ADDSUB_RANGE_CHK_EN
   ,
   output logic              out_err
`endif
);

   // Single conditional correction of a raw stage-1 value into [0, P)
   function automatic logic [DATA_W-1:0] mod_reduce(
      input logic              op,
      input logic [DATA_W:0]   raw,
      input logic              borrow
   );
      if (op == OP_ADD) begin
         if (raw >= {1'b0, MODULUS}) begin
            return raw[DATA_W-1:0] - MODULUS;
         end
         return raw[DATA_W-1:0];
      end
      if (borrow) begin
         return raw[DATA_W-1:0] + MODULUS;
      end
      return raw[DATA_W-1:0];
   endfunction

`ifdef MOD_ADDSUB_RANGE_CHK_EN
   localparam int ERR_W = 1;
`else
   localparam int ERR_W = 0;
`endif
   // Stage 1 bundle: valid, err?, tag, op, borrow, raw
   localparam int S1_W = 1 + ERR_W + TAG_W + 1 + 1 + DATA_W + 1;
   // Stage 2 bundle: valid, err?, tag, res
   localparam int S2_W = 1 + ERR_W + TAG_W + DATA_W;

   logic              s1_en;
   logic              s2_en;
   logic              s1_valid;
   logic              s2_valid;

   logic [DATA_W:0]   raw_d;
   logic              borrow_d;
   logic [S1_W-1:0]   s1_d;
   logic [S1_W-1:0]   s1_q;
   logic [S2_W-1:0]   s2_d;
   logic [S2_W-1:0]   s2_q;

   logic [DATA_W:0]   s1_raw;
   logic              s1_borrow;
   logic              s1_op;
   logic [TAG_W-1:0]  s1_tag;

   // A stage may load when it is empty or its contents move on this cycle
   assign s2_en    = !s2_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   // Raw sum (with carry) or wrapped difference (with borrow) of the operands
   always_comb begin
      raw_d    = '0;
      borrow_d = 1'b0;
      if (in_op == OP_SUB) begin
         raw_d    = {1'b0, in_a - in_b};
         borrow_d = (in_a < in_b);
      end else begin
         raw_d    = {1'b0, in_a} + {1'b0, in_b};
      end
   end

   // ---- stage 1 boundary ----
`ifdef MOD_ADDSUB_RANGE_CHK_EN
   logic range_err_d;
   logic s1_err;
   assign range_err_d = (in_a >= MODULUS) || (in_b >= MODULUS);
   assign s1_d = {in_valid, range_err_d, in_tag, in_op, borrow_d, raw_d};
   assign {s1_valid, s1_err, s1_tag, s1_op, s1_borrow, s1_raw} = s1_q;
`else
   assign s1_d = {in_valid, in_tag, in_op, borrow_d, raw_d};
   assign {s1_valid, s1_tag, s1_op, s1_borrow, s1_raw} = s1_q;
`endif

   pipe_stage_reg #(.W(S1_W)) u_stage1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (s1_en),
      .d     (s1_d),
      .q     (s1_q)
   );

   // ---- stage 2 boundary ----
`ifdef MOD_ADDSUB_RANGE_CHK_EN
   assign s2_d = {s1_valid, s1_err, s1_tag, mod_reduce(s1_op, s1_raw, s1_borrow)};
   assign {s2_valid, out_err, out_tag, out_res} = s2_q;
`else
   assign s2_d = {s1_valid, s1_tag, mod_reduce(s1_op, s1_raw, s1_borrow)};
   assign {s2_valid, out_tag, out_res} = s2_q;
`endif

   pipe_stage_reg #(.W(S2_W)) u_stage2 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (s2_en),
      .d     (s2_d),
      .q     (s2_q)
   );

   assign out_valid = s2_valid;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: directed field-boundary cases,
// streaming, backpressure, reset flush and randomized traffic with random
// output stalls, all compared against a modular-arithmetic reference model.
module tb_mod_addsub_pipe;

   localparam logic [255:0] P =
      256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_op = 1'b0;
   logic [255:0] in_a = '0;
   logic [255:0] in_b = '0;
   logic [7:0]   in_tag = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [255:0] out_res;
   logic [7:0]   out_tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
   logic         out_err;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [255:0] res;
      logic [7:0]   tag;
      logic         err;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];

   mod_addsub_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      ,
      .out_err   (out_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: modular arithmetic straight from the definition
   function automatic logic [255:0] ref_res(input bit op, input logic [255:0] a, input logic [255:0] b);
      logic [257:0] w;
      if (!op) w = ({2'b0, a} + {2'b0, b}) % {2'b0, P};
      else     w = ({2'b0, a} + {2'b0, P} - {2'b0, b}) % {2'b0, P};
      return w[255:0];
   endfunction

   function automatic logic [255:0] rand_val();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return P - 1;
         default: return v % P;
      endcase
   endfunction

   // Issue one pair (called just after a falling edge); returns just after
   // the next falling edge once it has been accepted.
   task automatic send(input bit op, input logic [255:0] a, input logic [255:0] b,
                       input logic [7:0] tag, input bit lat, input bit rnd_bp, output int waits);
      exp_t e;
      waits = 0;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_tag = tag;
      #1;
      while (!in_ready && waits < 100) begin
         @(negedge clk);
         if (rnd_bp) out_ready = ($urandom_range(0, 2) != 0);
         #1;
         waits++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%0d required 1", in_ready);
      end else begin
         e.res = ref_res(op, a, b);
         e.tag = tag;
         e.err = (a >= P) || (b >= P);
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
      end
      @(negedge clk);
   endtask

   // Monitor: compares the presented result with the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: out_valid=1 tag=%h required no output", out_tag);
            end else begin
               e = sb[0];
               chk("out_res", out_res, e.res);
               chk("out_tag", {248'b0, out_tag}, {248'b0, e.tag});
`ifdef MOD_ADDSUB_RANGE_CHK_EN
               chk("out_err", {255'b0, out_err}, {255'b0, e.err});
`endif
               if (out_ready) begin
                  void'(sb.pop_front());
                  if (e.lat) chk("latency", 256'(cyc - e.acc), 256'd2);
               end
            end
         end
      end
   end

   initial begin
      int w;
      logic [7:0] t;
      // Reset state
      #3;
      chk("rst_out_valid", {255'b0, out_valid}, '0);
      chk("rst_out_res", out_res, '0);
      chk("rst_out_tag", {248'b0, out_tag}, '0);
      chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      chk("rst_out_err", {255'b0, out_err}, '0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", {255'b0, in_ready}, 256'd1);
      @(negedge clk);

      // Directed single operations
      send(1'b0, 256'd3, 256'd5, 8'h11, 1'b1, 1'b0, w);
      drain();
      send(1'b0, P - 1, 256'd2, 8'h21, 1'b1, 1'b0, w);
      send(1'b0, P - 1, P - 1, 8'h22, 1'b1, 1'b0, w);
      send(1'b0, 256'd0, 256'd0, 8'h23, 1'b1, 1'b0, w);
      send(1'b1, 256'd2, 256'd5, 8'h31, 1'b1, 1'b0, w);
      send(1'b1, 256'd7, 256'd7, 8'h32, 1'b1, 1'b0, w);
      send(1'b1, P - 1, 256'd0, 8'h33, 1'b1, 1'b0, w);
      drain();

      // Streaming six back-to-back operations
      for (int i = 0; i < 6; i++) begin
         send(i[0], rand_val(), rand_val(), 8'(i), 1'b1, 1'b0, w);
         chk("stream_in_ready", 256'(w), '0);
      end
      drain();

      // Backpressure: out_ready low for four cycles while in_valid high
      out_ready = 1'b0;
      send(1'b0, 256'd10, 256'd20, 8'h40, 1'b0, 1'b0, w);
      chk("bp_acc0", 256'(w), '0);
      send(1'b1, 256'd1, 256'd9, 8'h41, 1'b0, 1'b0, w);
      chk("bp_acc1", 256'(w), '0);
      in_valid = 1'b1;
      in_op = 1'b0;
      in_a = 256'd100;
      in_b = P - 50;
      in_tag = 8'h42;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("bp_in_ready_low", {255'b0, in_ready}, '0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(1'b0, 256'd100, P - 50, 8'h42, 1'b0, 1'b0, w);
      chk("bp_acc2", 256'(w), '0);
      send(1'b1, 256'd0, 256'd1, 8'h43, 1'b0, 1'b0, w);
      drain();

      // Reset with two operations in flight
      send(1'b0, 256'd4, 256'd4, 8'h51, 1'b0, 1'b0, w);
      send(1'b0, 256'd6, 256'd6, 8'h52, 1'b0, 1'b0, w);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_out_valid", {255'b0, out_valid}, '0);
      chk("mid_rst_out_res", out_res, '0);
      chk("mid_rst_in_ready", {255'b0, in_ready}, 256'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("post_rst_idle", {255'b0, out_valid}, '0);
         @(negedge clk);
      end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
      // Out-of-range operand flagged alongside its result
      send(1'b0, P, 256'd3, 8'h61, 1'b1, 1'b0, w);
      drain();
`endif

      // Randomized traffic with random output stalls
      for (int i = 0; i < 200; i++) begin
         out_ready = ($urandom_range(0, 2) != 0);
         t = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end else begin
            send(1'($urandom), rand_val(), rand_val(), t, 1'b0, 1'b1, w);
         end
      end
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: time=%0t required finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
